// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between the core (port 0)
// and the loader/debug port (port 1), with round-robin tie-break and done pulses.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              mem_we_q, mem_we_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sel_s;

  // Next-state and datapath decode; everything defaults to hold except pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_we_d = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    sel_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the port that did not win last time is served.
          sel_s    = (m0_req && m1_req) ? ~last_q : m1_req;
          gnt_d    = sel_s;
          addr_d   = sel_s ? m1_addr  : m0_addr;
          wdata_d  = sel_s ? m1_wdata : m0_wdata;
          we_d     = sel_s ? m1_we    : m0_we;
          mem_we_d = sel_s ? m1_we    : m0_we;
          cnt_d    = 4'(WAIT);
          state_d  = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          last_d  = gnt_q;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      mem_we_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      mem_we_q <= mem_we_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign m0_done   = done0_q;
  assign m1_done   = done1_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with WAIT=2, one with WAIT=0.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A (WAIT=2)
  logic        a_m0_req, a_m0_we, a_m0_done, a_m1_req, a_m1_we, a_m1_done;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_mem_we, a_busy, a_gnt_id;
  // Instance B (WAIT=0)
  logic        b_m0_req, b_m0_we, b_m0_done, b_m1_req, b_m1_we, b_m1_done;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_we, b_busy, b_gnt_id;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    else return a ^ 32'hC0DE_0000;
  endfunction

  assign a_mem_rdata = mem_model(a_mem_addr);
  assign b_mem_rdata = mem_model(b_mem_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(2)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_done(a_m0_done),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_done(a_m1_done),
    .rdata(a_rdata), .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .gnt_id(a_gnt_id)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_done(b_m0_done),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_done(b_m1_done),
    .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .gnt_id(b_gnt_id)
  );

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and run invariant and scoreboard checks.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      check_eq("a_done_excl", {31'd0, a_m0_done & a_m1_done}, 32'd0);
      check_eq("a_we_idle", {31'd0, a_mem_we & ~a_busy}, 32'd0);
      check_eq("b_done_excl", {31'd0, b_m0_done & b_m1_done}, 32'd0);
      check_eq("b_we_idle", {31'd0, b_mem_we & ~b_busy}, 32'd0);
      if (a_m0_done || a_m1_done) begin
        if (sb_a.size() == 0) check_eq("a_sb_unexpected_done", 32'd1, 32'd0);
        else begin
          e = sb_a.pop_front();
          check_eq("a_sb_port", {31'd0, a_m1_done}, {31'd0, e.port});
          if (e.rd) check_eq("a_sb_rdata", a_rdata, e.data);
        end
      end
      if (b_m0_done || b_m1_done) begin
        if (sb_b.size() == 0) check_eq("b_sb_unexpected_done", 32'd1, 32'd0);
        else begin
          e = sb_b.pop_front();
          check_eq("b_sb_port", {31'd0, b_m1_done}, {31'd0, e.port});
          if (e.rd) check_eq("b_sb_rdata", b_rdata, e.data);
        end
      end
    end
  endtask

  task automatic req_a(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit push);
    exp_t e;
    if (port) begin
      a_m1_req = 1'b1; a_m1_we = we; a_m1_addr = addr; a_m1_wdata = wd;
    end else begin
      a_m0_req = 1'b1; a_m0_we = we; a_m0_addr = addr; a_m0_wdata = wd;
    end
    if (push) begin
      e.port = port; e.rd = ~we; e.data = mem_model(addr);
      sb_a.push_back(e);
    end
  endtask

  // Wait for a done pulse on the chosen instance/port, dropping req on it.
  task automatic wait_done(input bit dut, input bit port, output int at);
    logic d;
    at = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      d = dut ? (port ? b_m1_done : b_m0_done) : (port ? a_m1_done : a_m0_done);
      if (d === 1'b1) begin
        at = cyc;
        if (dut) begin
          if (port) b_m1_req = 1'b0; else b_m0_req = 1'b0;
        end else begin
          if (port) a_m1_req = 1'b0; else a_m0_req = 1'b0;
        end
        break;
      end
    end
    if (at < 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int   t0, at0, at1;
    exp_t e;
    rst = 1'b0;
    a_m0_req = 1'b0; a_m0_we = 1'b0; a_m0_addr = 32'd0; a_m0_wdata = 32'd0;
    a_m1_req = 1'b0; a_m1_we = 1'b0; a_m1_addr = 32'd0; a_m1_wdata = 32'd0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 32'd0; b_m0_wdata = 32'd0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 32'd0; b_m1_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    check_eq("rst_busy", {31'd0, a_busy}, 32'd0);
    check_eq("rst_done", {30'd0, a_m1_done, a_m0_done}, 32'd0);
    check_eq("rst_rdata", a_rdata, 32'd0);
    check_eq("rst_addr", a_mem_addr, 32'd0);
    check_eq("rst_wdata", a_mem_wdata, 32'd0);
    check_eq("rst_we", {31'd0, a_mem_we}, 32'd0);
    check_eq("rst_gnt", {31'd0, a_gnt_id}, 32'd0);

    // Read with WAIT=2: done in cycle 4, busy in cycles 1-4.
    req_a(1'b0, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      tick();
      check_eq("t1_busy", {31'd0, a_busy}, {31'd0, (n <= 4)});
      check_eq("t1_done", {31'd0, a_m0_done}, {31'd0, (n == 4)});
      check_eq("t1_we", {31'd0, a_mem_we}, 32'd0);
      if (n == 4) a_m0_req = 1'b0;
    end
    check_eq("t1_rdata", a_rdata, 32'hDEAD_BEEF);

    // Write: one-cycle strobe, stable address/data, rdata untouched.
    req_a(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      tick();
      check_eq("t2_we", {31'd0, a_mem_we}, {31'd0, (n == 1)});
      check_eq("t2_addr", a_mem_addr, 32'h0000_0020);
      check_eq("t2_wdata", a_mem_wdata, 32'h1234_5678);
      check_eq("t2_rdata", a_rdata, 32'hDEAD_BEEF);
      check_eq("t2_done", {31'd0, a_m0_done}, {31'd0, (n == 4)});
      if (n == 4) a_m0_req = 1'b0;
    end

    // Tie after reset: m0 first, then m1, then m0 again.
    do_reset();
    check_eq("t3_rdata_rst", a_rdata, 32'd0);
    t0 = cyc;
    req_a(1'b0, 1'b0, 32'h0000_0030, 32'd0, 1'b1);
    req_a(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b1);
    tick();
    check_eq("t3_gnt0", {31'd0, a_gnt_id}, 32'd0);
    wait_done(1'b0, 1'b0, at0);
    check_eq("t3_lat0", at0 - t0, 32'd4);
    wait_done(1'b0, 1'b1, at1);
    check_eq("t3_gap", at1 - at0, 32'd5);
    check_eq("t3_gnt1", {31'd0, a_gnt_id}, 32'd1);
    tick();
    t0 = cyc;
    req_a(1'b0, 1'b0, 32'h0000_0034, 32'd0, 1'b1);
    req_a(1'b1, 1'b0, 32'h0000_0044, 32'd0, 1'b1);
    tick();
    check_eq("t3_alt_gnt", {31'd0, a_gnt_id}, 32'd0);
    wait_done(1'b0, 1'b0, at0);
    check_eq("t3_alt_lat", at0 - t0, 32'd4);
    wait_done(1'b0, 1'b1, at1);
    check_eq("t3_alt_gap", at1 - at0, 32'd5);

    // m1 raises req during m0's ACCESS.
    tick();
    t0 = cyc;
    req_a(1'b0, 1'b0, 32'h0000_0050, 32'd0, 1'b1);
    tick();
    req_a(1'b1, 1'b0, 32'h0000_0060, 32'd0, 1'b1);
    check_eq("t4_gnt", {31'd0, a_gnt_id}, 32'd0);
    wait_done(1'b0, 1'b0, at0);
    check_eq("t4_lat", at0 - t0, 32'd4);
    wait_done(1'b0, 1'b1, at1);
    check_eq("t4_gap", at1 - at0, 32'd5);

    // Reset in the second ACCESS cycle of a write abandons it.
    tick();
    req_a(1'b0, 1'b1, 32'h0000_0070, 32'hCAFE_F00D, 1'b0);
    tick();
    check_eq("t5_we", {31'd0, a_mem_we}, 32'd1);
    tick();
    rst = 1'b0;
    a_m0_req = 1'b0;
    tick();
    check_eq("t5_we_rst", {31'd0, a_mem_we}, 32'd0);
    check_eq("t5_busy_rst", {31'd0, a_busy}, 32'd0);
    check_eq("t5_gnt_rst", {31'd0, a_gnt_id}, 32'd0);
    check_eq("t5_done_rst", {31'd0, a_m0_done}, 32'd0);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check_eq("t5_no_done", {31'd0, a_m0_done}, 32'd0);
    end
    req_a(1'b0, 1'b0, 32'h0000_0080, 32'd0, 1'b1);
    req_a(1'b1, 1'b0, 32'h0000_0090, 32'd0, 1'b1);
    tick();
    check_eq("t5_tie_gnt", {31'd0, a_gnt_id}, 32'd0);
    wait_done(1'b0, 1'b0, at0);
    wait_done(1'b0, 1'b1, at1);

    // WAIT=0 back-to-back reads.
    tick();
    t0 = cyc;
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h0000_0004;
    e.port = 1'b0; e.rd = 1'b1; e.data = mem_model(32'h0000_0004); sb_b.push_back(e);
    wait_done(1'b1, 1'b0, at0);
    check_eq("t6_lat", at0 - t0, 32'd2);
    check_eq("t6_rdata0", b_rdata, 32'hC0DE_0004);
    tick();
    b_m0_req = 1'b1; b_m0_addr = 32'h0000_0008;
    e.port = 1'b0; e.rd = 1'b1; e.data = mem_model(32'h0000_0008); sb_b.push_back(e);
    wait_done(1'b1, 1'b0, at1);
    check_eq("t6_gap", at1 - at0, 32'd3);
    check_eq("t6_rdata1", b_rdata, 32'hC0DE_0008);

    repeat (3) tick();
    check_eq("sb_a_empty", sb_a.size(), 32'd0);
    check_eq("sb_b_empty", sb_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle RISC-V core between two requesters.
- Port 0 is the core's fetch/load/store path; port 1 is the program loader/debug port.
- Serialises accesses, sequences a memory with a fixed read latency (WAIT cycles), and returns a one-cycle done pulse per transaction.
- Round-robin tie-break so neither requester starves.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT, 1, extra memory cycles beyond the first before read data is valid (0..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset (0 = reset, sampled on clk rising edge).
- m0_req  input  1  port 0 request; held high until m0_done is seen.
- m0_we  input  1  port 0 write enable (1 = write, 0 = read).
- m0_addr  input  ADDR_W  port 0 address.
- m0_wdata  input  DATA_W  port 0 write data.
- m0_done  output  1  port 0 transaction complete; one-cycle pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_done: same as port 0, for port 1.
- rdata  output  DATA_W  read data of the last completed read; valid when either done is high and that transaction was a read.
- mem_addr  output  ADDR_W  address to memory.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  DATA_W  write data to memory.
- mem_rdata  input  DATA_W  read data from memory.
- busy  output  1  high whenever state is not IDLE.
- gnt_id  output  1  port owning the current or last transaction.

Behaviour:
- Reset (rst = 0 at an edge):
  - State goes to IDLE.
  - m0_done, m1_done, mem_we, busy, rdata, mem_addr, mem_wdata = 0.
  - gnt_id = 0; last_grant = 1, so port 0 wins the first tie.
  - Reset mid-transaction abandons it: no done pulse, and mem_we = 0 from the next cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one req is high at an edge: grant it.
  - If both are high: grant the port not equal to last_grant.
  - On grant: latch addr/we/wdata into mem_addr/mem_wdata and an internal we_q; set gnt_id; load cnt = WAIT; go to ACCESS.
  - No req: stay in IDLE, outputs hold.
- ACCESS:
  - Lasts exactly WAIT+1 cycles; cnt decrements each cycle.
  - mem_we = we_q in the first ACCESS cycle only, 0 afterwards.
  - mem_addr and mem_wdata are stable for the whole state.
  - On the edge where cnt == 0: if a read, register mem_rdata into rdata; set last_grant = gnt_id; go to RESP.
- RESP:
  - Exactly one cycle. The granted port's done = 1; the other port's done = 0. Next state is IDLE.
- Requester rule: deassert req at the edge ending the done cycle. A req still high in the following IDLE cycle is a new request.
- Latency: req high in IDLE cycle 0 gives done high in cycle WAIT+2. Minimum spacing between two grants is WAIT+3 cycles.
- Requests arriving while busy are not lost. They are held by the requester, seen in the next IDLE, and arbitrated then.
- Input changes on a granted port during ACCESS/RESP are ignored, because the values were latched at grant.
- rdata holds its value across writes and idle periods; it changes only at the end of a read.
- Both done outputs are never high together; mem_we is never high outside ACCESS.
- The cnt width covers WAIT up to 15 and never wraps; WAIT = 0 gives a single ACCESS cycle.

Test Plan:
- WAIT=2, m0 read 0x0000_0010 with mem_rdata = 0xDEADBEEF: m0_done high in cycle 4 only; rdata = 0xDEADBEEF; mem_we stays 0; busy high in cycles 1-4.
- m0 write 0x20 <- 0x12345678: mem_we high for exactly one cycle (cycle 1); mem_addr = 0x20 and mem_wdata = 0x12345678 through ACCESS; rdata unchanged.
- Both req high after reset: m0 served first (gnt_id = 0). m1 is served next without a gap beyond IDLE, with gnt_id = 1. Repeating the tie then grants m0, i.e. strict alternation.
- m1 raises req in m0's ACCESS cycle: m1 is not granted until the IDLE after m0_done; m1_done occurs WAIT+3 cycles after m0_done.
- rst = 0 in the second ACCESS cycle of a write: no done pulse, mem_we = 0 and busy = 0 after the edge, gnt_id = 0, and the next tie grants m0.
- WAIT=0, back-to-back m0 reads at 0x4 and 0x8 (req re-asserted in the IDLE cycle): done pulses 3 cycles apart with the correct rdata for each.
